// File: rtl/dac_spi_pkg.sv
// Shared sequencer state encoding and frame timing helpers for the DAC SPI sequencer.
package dac_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_GAP,
      ST_LDAC,
      ST_ACK
   } state_e;

   function automatic int gapLen(input int div);
      return 2 * div;
   endfunction

   function automatic int frameLen(input int cw, input int dw, input int div);
      return 1 + 2 * div * (cw + dw) + gapLen(div);
   endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// Serialises one frame MSB first: SCK low for DIV cycles then high for DIV cycles per bit,
// with the data bit advancing only on the SCK falling transition.
module dac_spi_shifter #(
   parameter int FW  = 24,
   parameter int DIV = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          shift_i,
   input  logic [FW-1:0] frame_i,
   output logic          sck_o,
   output logic          sdi_o,
   output logic          frameDone_o
);

   localparam int BW = (FW > 1) ? $clog2(FW) : 1;

   logic [FW-1:0] shreg_q, shreg_d;
   logic [7:0]    divCnt_q, divCnt_d;
   logic          sckHigh_q, sckHigh_d;
   logic [BW-1:0] bitCnt_q, bitCnt_d;
   logic          phaseEnd;

   assign phaseEnd    = (divCnt_q == 8'(DIV - 1));
   assign frameDone_o = shift_i && phaseEnd && sckHigh_q && (bitCnt_q == BW'(FW - 1));
   assign sck_o       = sckHigh_q;
   assign sdi_o       = shreg_q[FW-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q   <= '0;
         divCnt_q  <= '0;
         sckHigh_q <= 1'b0;
         bitCnt_q  <= '0;
      end else begin
         shreg_q   <= shreg_d;
         divCnt_q  <= divCnt_d;
         sckHigh_q <= sckHigh_d;
         bitCnt_q  <= bitCnt_d;
      end
   end

   always_comb begin
      shreg_d   = shreg_q;
      divCnt_d  = divCnt_q;
      sckHigh_d = sckHigh_q;
      bitCnt_d  = bitCnt_q;
      if (load_i) begin
         shreg_d   = frame_i;
         divCnt_d  = '0;
         sckHigh_d = 1'b0;
         bitCnt_d  = '0;
      end else if (shift_i) begin
         if (phaseEnd) begin
            divCnt_d  = '0;
            sckHigh_d = ~sckHigh_q;
            // The end of a high phase is the falling edge: move on to the next bit.
            if (sckHigh_q) begin
               shreg_d  = {shreg_q[FW-2:0], 1'b0};
               bitCnt_d = bitCnt_q + BW'(1);
            end
         end else begin
            divCnt_d = divCnt_q + 8'd1;
         end
      end
   end

endmodule

// File: rtl/dac_spi_seq.sv
// Multi-channel DAC SPI sequencer: snapshots the frame set, sends enabled frames in ascending order,
// optionally pulses LDAC (macro DAC_SPI_SEQ_LDAC_EN) and acknowledges with a start/done handshake.
module dac_spi_seq
   import dac_spi_pkg::*;
#(
   parameter int NCH = 8,
   parameter int CW  = 8,
   parameter int DW  = 16,
   parameter int DIV = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NCH-1:0]    ch_mask,
   input  logic [NCH*CW-1:0] dac_cmd,
   input  logic [NCH*DW-1:0] dac_data,
   output logic              busy,
   output logic              ready,
   output logic              done,
   output logic              dac_cs_n,
   output logic              dac_sck,
   output logic              dac_sdi,
   output logic              dac_ldac_n
);

   localparam int          FW       = CW + DW;
   localparam int          IW       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [15:0] GAP_LAST = 16'(gapLen(DIV) - 1);

`ifdef DAC_SPI_SEQ_LDAC_EN
   localparam state_e POST_ST = ST_LDAC;
`else
   localparam state_e POST_ST = ST_ACK;
`endif

   state_e            state_q, state_d;
   logic              pend_q, pend_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [NCH-1:0]    mask_q, mask_d;
   logic [NCH*CW-1:0] cmd_q, cmd_d;
   logic [NCH*DW-1:0] data_q, data_d;

   logic [IW-1:0] firstIdx, nextIdx;
   logic          firstFound, nextFound;
   logic [FW-1:0] curFrame;
   logic          shSck, shSdi, frameDone;

   assign curFrame = {cmd_q[idx_q*CW +: CW], data_q[idx_q*DW +: DW]};

   dac_spi_shifter #(
      .FW (FW),
      .DIV(DIV)
   ) u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (state_q == ST_LOAD),
      .shift_i    (state_q == ST_SHIFT),
      .frame_i    (curFrame),
      .sck_o      (shSck),
      .sdi_o      (shSdi),
      .frameDone_o(frameDone)
   );

   // pend_q resets high so the power-on load runs without a start request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= 1'b1;
         idx_q   <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         cmd_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         cmd_q   <= cmd_d;
         data_q  <= data_d;
      end
   end

   // Lowest enabled frame of the live mask (sequence entry) and next enabled frame above idx_q.
   always_comb begin
      firstIdx   = '0;
      firstFound = 1'b0;
      nextIdx    = '0;
      nextFound  = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            firstIdx   = IW'(i);
            firstFound = 1'b1;
         end
         if (mask_q[i] && (i > int'(idx_q))) begin
            nextIdx   = IW'(i);
            nextFound = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      cmd_d   = cmd_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (pend_q || start) begin
               pend_d = 1'b0;
               mask_d = ch_mask;
               cmd_d  = dac_cmd;
               data_d = dac_data;
               cnt_d  = '0;
               if (firstFound) begin
                  idx_d   = firstIdx;
                  state_d = ST_LOAD;
               end else begin
                  state_d = POST_ST;
               end
            end
         end
         ST_LOAD: state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (frameDone) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (nextFound) begin
                  idx_d   = nextIdx;
                  state_d = ST_LOAD;
               end else begin
                  state_d = POST_ST;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_LDAC: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_ACK: begin
            if (!start) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      ready      = 1'b0;
      done       = 1'b0;
      dac_cs_n   = 1'b1;
      dac_sck    = 1'b0;
      dac_sdi    = 1'b0;
      dac_ldac_n = 1'b1;
      case (state_q)
         ST_IDLE: ready = ~pend_q;
         ST_LOAD: begin
            busy     = 1'b1;
            dac_cs_n = 1'b0;
            dac_sdi  = curFrame[FW-1];
         end
         ST_SHIFT: begin
            busy     = 1'b1;
            dac_cs_n = 1'b0;
            dac_sck  = shSck;
            dac_sdi  = shSdi;
         end
         ST_GAP: busy = 1'b1;
         ST_LDAC: begin
            busy = 1'b1;
`ifdef DAC_SPI_SEQ_LDAC_EN
            dac_ldac_n = 1'b0;
`endif
         end
         ST_ACK: done = start;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dac_spi_seq.sv
// Directed bench for dac_spi_seq: a default instance (DIV=1) and a DIV=3 instance, with a bus
// monitor that records CS windows, SCK-captured frames and handshake activity.
`timescale 1ns/1ps
module tb_dac_spi_seq;

   localparam int FW = 24;
`ifdef DAC_SPI_SEQ_LDAC_EN
   localparam int LDAC0 = 2;
   localparam int LDAC1 = 6;
`else
   localparam int LDAC0 = 0;
   localparam int LDAC1 = 0;
`endif

   logic         clk = 1'b0;
   logic         rst0, rst1, start0, start1;
   logic [7:0]   mask0, mask1;
   logic [63:0]  cmd0, cmd1;
   logic [127:0] data0, data1;
   logic         busy0, ready0, done0, cs0, sck0, sdi0, ldac0;
   logic         busy1, ready1, done1, cs1, sck1, sdi1, ldac1;

   dac_spi_seq #(.NCH(8), .CW(8), .DW(16), .DIV(1)) dut0 (
      .clk(clk), .rst_n(rst0), .start(start0), .ch_mask(mask0), .dac_cmd(cmd0), .dac_data(data0),
      .busy(busy0), .ready(ready0), .done(done0), .dac_cs_n(cs0), .dac_sck(sck0), .dac_sdi(sdi0),
      .dac_ldac_n(ldac0)
   );

   dac_spi_seq #(.NCH(8), .CW(8), .DW(16), .DIV(3)) dut1 (
      .clk(clk), .rst_n(rst1), .start(start1), .ch_mask(mask1), .dac_cmd(cmd1), .dac_data(data1),
      .busy(busy1), .ready(ready1), .done(done1), .dac_cs_n(cs1), .dac_sck(sck1), .dac_sdi(sdi1),
      .dac_ldac_n(ldac1)
   );

   always #5 clk = ~clk;

   logic [1:0] csV, sckV, sdiV, ldacV, busyV, doneV, readyV;
   assign csV    = {cs1, cs0};
   assign sckV   = {sck1, sck0};
   assign sdiV   = {sdi1, sdi0};
   assign ldacV  = {ldac1, ldac0};
   assign busyV  = {busy1, busy0};
   assign doneV  = {done1, done0};
   assign readyV = {ready1, ready0};

   int testCnt = 0;
   int failCnt = 0;
   int winCnt[2], curLen[2], bitIdx[2], busyCyc[2], ldacCyc[2];
   int donePulse[2], sckViol[2], sdiViol[2], sckRise[2];
   int lens[2][16];
   logic [FW-1:0] bitsCur[2];
   logic [FW-1:0] frames[2][16];
   logic [1:0] csP = 2'b11, sckP = 2'b00, sdiP = 2'b00, doneP = 2'b00;

   // Bus monitor, sampled on the falling clock edge.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!csV[d]) curLen[d]++;
         if (sckV[d] && !sckP[d]) sckRise[d]++;
         if (!csV[d] && sckV[d] && !sckP[d]) begin
            bitsCur[d] = {bitsCur[d][FW-2:0], sdiV[d]};
            bitIdx[d]++;
         end
         if (csV[d] && csP[d] && (sckV[d] !== sckP[d])) sckViol[d]++;
         if (sckV[d] && sckP[d] && (sdiV[d] !== sdiP[d])) sdiViol[d]++;
         if (csV[d] && !csP[d]) begin
            if (winCnt[d] < 16) begin
               frames[d][winCnt[d]] = bitsCur[d];
               lens[d][winCnt[d]]   = curLen[d];
            end
            winCnt[d]++;
            curLen[d]  = 0;
            bitIdx[d]  = 0;
            bitsCur[d] = '0;
         end
         if (busyV[d]) busyCyc[d]++;
         if (!ldacV[d]) ldacCyc[d]++;
         if (doneV[d] && !doneP[d]) donePulse[d]++;
      end
      csP   = csV;
      sckP  = sckV;
      sdiP  = sdiV;
      doneP = doneV;
   end

   task automatic clearMon(input int d);
      winCnt[d]    = 0;
      curLen[d]    = 0;
      bitIdx[d]    = 0;
      busyCyc[d]   = 0;
      ldacCyc[d]   = 0;
      donePulse[d] = 0;
      sckViol[d]   = 0;
      sdiViol[d]   = 0;
      sckRise[d]   = 0;
      bitsCur[d]   = '0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] m, input logic s);
      @(posedge clk);
      #1;
      mask0  = m;
      start0 = s;
   endtask

   // Frame i of dut0 is {8'h33 + i, 16'h1234 + i * 16'h0101}.
   task automatic fillFrames0();
      for (int i = 0; i < 8; i++) begin
         cmd0[i*8 +: 8]    = 8'h33 + 8'(i);
         data0[i*16 +: 16] = 16'h1234 + 16'(i) * 16'h0101;
      end
   endtask

   // which = 0 waits for ready, which = 1 waits for done; returns on a falling edge.
   task automatic waitFor(input int d, input int which, input int bound, input string tag);
      int n = 0;
      while ((((which == 0) ? readyV[d] : doneV[d]) !== 1'b1) && (n < bound)) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, " reached"}, 32'(n < bound), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no completion, required finish before 200us");
      $fatal(1);
   end

   initial begin
      int r;
      rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
      mask0 = 8'hFF; mask1 = 8'h05; cmd0 = '0; data0 = '0; cmd1 = '0; data1 = '0;
      fillFrames0();
      #1 rst0 = 1'b0; rst1 = 1'b0;
      #1;
      checkOutput("rst cs_n", 32'(cs0), 32'd1);
      checkOutput("rst sck", 32'(sck0), 32'd0);
      checkOutput("rst sdi", 32'(sdi0), 32'd0);
      checkOutput("rst ldac_n", 32'(ldac0), 32'd1);
      checkOutput("rst busy", 32'(busy0), 32'd0);
      checkOutput("rst ready", 32'(ready0), 32'd0);
      checkOutput("rst done", 32'(done0), 32'd0);

      // Power-on sequence, all eight frames
      @(posedge clk);
      clearMon(0);
      #2 rst0 = 1'b1;
      waitFor(0, 0, 2000, "poweron ready");
      @(posedge clk);
      checkOutput("poweron windows", 32'(winCnt[0]), 32'd8);
      checkOutput("poweron len0", 32'(lens[0][0]), 32'd49);
      checkOutput("poweron len7", 32'(lens[0][7]), 32'd49);
      checkOutput("poweron frame0", 32'(frames[0][0]), 32'h331234);
      checkOutput("poweron frame3", 32'(frames[0][3]), 32'h361537);
      checkOutput("poweron frame7", 32'(frames[0][7]), 32'h3A193B);
      checkOutput("poweron busy cycles", 32'(busyCyc[0]), 32'(408 + LDAC0));
      checkOutput("poweron ldac cycles", 32'(ldacCyc[0]), 32'(LDAC0));
      checkOutput("poweron done pulses", 32'(donePulse[0]), 32'd0);
      checkOutput("poweron sck while cs high", 32'(sckViol[0]), 32'd0);
      checkOutput("poweron sdi while sck high", 32'(sdiViol[0]), 32'd0);

      // Empty mask: straight to LDAC/ACK
      clearMon(0);
      applyStimulus(8'h00, 1'b1);
      waitFor(0, 1, 100, "mask0 done");
      checkOutput("mask0 ready during ack", 32'(ready0), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("mask0 done held", 32'(done0), 32'd1);
      @(posedge clk);
      #1 start0 = 1'b0;
      @(negedge clk);
      checkOutput("mask0 done drops", 32'(done0), 32'd0);
      checkOutput("mask0 ready not yet", 32'(ready0), 32'd0);
      @(negedge clk);
      checkOutput("mask0 ready next", 32'(ready0), 32'd1);
      @(posedge clk);
      checkOutput("mask0 windows", 32'(winCnt[0]), 32'd0);
      checkOutput("mask0 busy cycles", 32'(busyCyc[0]), 32'(LDAC0));
      checkOutput("mask0 done pulses", 32'(donePulse[0]), 32'd1);

      // Snapshot isolation and re-request while busy
      clearMon(0);
      cmd0[7:0] = 8'h33; data0[15:0] = 16'h1234;
      cmd0[15:8] = 8'h44; data0[31:16] = 16'h5678;
      applyStimulus(8'h03, 1'b1);
      repeat (10) @(posedge clk);
      #1 cmd0 = '0; data0 = '1; start0 = 1'b0;
      repeat (5) @(posedge clk);
      #1 start0 = 1'b1;
      waitFor(0, 1, 500, "snapshot done");
      @(posedge clk);
      checkOutput("snapshot windows", 32'(winCnt[0]), 32'd2);
      checkOutput("snapshot frame0", 32'(frames[0][0]), 32'h331234);
      checkOutput("snapshot frame1", 32'(frames[0][1]), 32'h445678);
      checkOutput("snapshot done pulses", 32'(donePulse[0]), 32'd1);
      #1 start0 = 1'b0;
      waitFor(0, 0, 20, "snapshot ready");
      repeat (30) @(posedge clk);
      checkOutput("snapshot no rerun", 32'(winCnt[0]), 32'd2);
      @(negedge clk);
      checkOutput("snapshot idle busy", 32'(busy0), 32'd0);

      // Reset at bit 10 of frame 3, then full rerun
      mask0 = 8'hFF;
      fillFrames0();
      @(posedge clk);
      #1 rst0 = 1'b0;
      @(posedge clk);
      clearMon(0);
      #1 rst0 = 1'b1;
      r = 0;
      while (!((winCnt[0] == 3) && (bitIdx[0] == 10)) && (r < 1000)) begin
         @(posedge clk);
         r++;
      end
      checkOutput("abort point reached", 32'(r < 1000), 32'd1);
      #1 rst0 = 1'b0;
      #1;
      checkOutput("abort cs_n", 32'(cs0), 32'd1);
      checkOutput("abort sck", 32'(sck0), 32'd0);
      checkOutput("abort sdi", 32'(sdi0), 32'd0);
      checkOutput("abort busy", 32'(busy0), 32'd0);
      checkOutput("abort ready", 32'(ready0), 32'd0);
      r = sckRise[0];
      repeat (5) @(posedge clk);
      checkOutput("abort no sck edges", 32'(sckRise[0]), 32'(r));
      clearMon(0);
      #1 rst0 = 1'b1;
      waitFor(0, 0, 2000, "rerun ready");
      @(posedge clk);
      checkOutput("rerun windows", 32'(winCnt[0]), 32'd8);
      checkOutput("rerun frame0", 32'(frames[0][0]), 32'h331234);
      checkOutput("rerun frame3", 32'(frames[0][3]), 32'h361537);

      // DIV=3 instance, frames 0 and 2 only
      cmd1[7:0] = 8'hA5;   data1[15:0]  = 16'h0F0F;
      cmd1[15:8] = 8'hFF;  data1[31:16] = 16'hFFFF;
      cmd1[23:16] = 8'h5A; data1[47:32] = 16'hC3C3;
      clearMon(1);
      @(posedge clk);
      #1 rst1 = 1'b1;
      waitFor(1, 0, 3000, "div3 ready");
      @(posedge clk);
      checkOutput("div3 windows", 32'(winCnt[1]), 32'd2);
      checkOutput("div3 len0", 32'(lens[1][0]), 32'd145);
      checkOutput("div3 len1", 32'(lens[1][1]), 32'd145);
      checkOutput("div3 frame0", 32'(frames[1][0]), 32'hA50F0F);
      checkOutput("div3 frame2", 32'(frames[1][1]), 32'h5AC3C3);
      checkOutput("div3 busy cycles", 32'(busyCyc[1]), 32'(302 + LDAC1));
      checkOutput("div3 ldac cycles", 32'(ldacCyc[1]), 32'(LDAC1));
      checkOutput("div3 sck while cs high", 32'(sckViol[1]), 32'd0);
      checkOutput("div3 sdi while sck high", 32'(sdiViol[1]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule
